// File: rtl/dot_tracker.sv
// Collectible-dot bookkeeping for a maze game: tracks which dots remain, scores
// each dot once per level, times power mode in frames and flags level completion.
module dot_tracker #(
    parameter int                N_DOTS       = 16,
    parameter int                IDX_W        = 6,
    parameter int                SCORE_W      = 10,
    parameter logic [N_DOTS-1:0] POWER_MASK   = N_DOTS'('h0011),
    parameter int                DOT_PTS      = 1,
    parameter int                POWER_PTS    = 5,
    parameter int                POWER_FRAMES = 300
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic               restart,
    input  logic               pix_valid,
    input  logic               is_pac,
    input  logic               dot_hit,
    input  logic [IDX_W-1:0]   dot_idx,
    output logic [N_DOTS-1:0]  alive,
    output logic               dot_draw,
    output logic               eat_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               power_active,
    output logic               level_clear
);

    localparam int PWR_W = $clog2(POWER_FRAMES + 1);
    localparam int SUM_W = SCORE_W + 32;

    logic [N_DOTS-1:0]  dot_sel;
    logic               idx_ok;
    logic               sel_alive;
    logic               sel_power;
    logic               visible;
    logic               eat;
    logic [31:0]        pts;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] score_next;
    logic [PWR_W-1:0]   power_cnt;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        idx_ok     = 1'b0;
        dot_sel    = '0;
        sel_alive  = 1'b0;
        sel_power  = 1'b0;
        visible    = 1'b0;
        eat        = 1'b0;
        pts        = '0;
        sum        = '0;
        score_next = score;

        // Out-of-range indices select nothing, so they can neither draw nor eat.
        idx_ok = (32'(dot_idx) < N_DOTS);
        if (idx_ok) begin
            dot_sel = N_DOTS'(1) << dot_idx;
        end
        sel_alive = |(alive & dot_sel);
        sel_power = |(POWER_MASK & dot_sel);

        visible = pix_valid & dot_hit & sel_alive;
        eat     = visible & is_pac & ~restart;

        pts = sel_power ? 32'(POWER_PTS) : 32'(DOT_PTS);
        sum = SUM_W'(score) + SUM_W'(pts);
        if (sum > SUM_W'({SCORE_W{1'b1}})) begin
            score_next = '1;
        end else begin
            score_next = sum[SCORE_W-1:0];
        end
    end

    // NOTE: alive is a flop bitmap, not a RAM, so giving it a reset value of
    // all ones is legitimate and every dot is visible straight out of reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            alive <= '1;
        end else if (restart) begin
            alive <= '1;
        end else if (eat) begin
            alive <= alive & ~dot_sel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dot_draw  <= 1'b0;
            eat_pulse <= 1'b0;
        end else begin
            dot_draw  <= visible;
            eat_pulse <= eat;
        end
    end

    // Score survives a restart; it only ever saturates upward.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score <= '0;
        end else if (eat) begin
            score <= score_next;
        end
    end

    // A pellet eat reloads the timer and takes priority over that frame's tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            power_cnt <= '0;
        end else if (restart) begin
            power_cnt <= '0;
        end else if (eat && sel_power) begin
            power_cnt <= PWR_W'(POWER_FRAMES);
        end else if (frame_start && (power_cnt != '0)) begin
            power_cnt <= power_cnt - 1'b1;
        end
    end

    assign power_active = (power_cnt != '0);

    // Sticky until restart; looks at the registered bitmap, hence one cycle late.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_clear <= 1'b0;
        end else if (restart) begin
            level_clear <= 1'b0;
        end else if (alive == '0) begin
            level_clear <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_tracker.sv
// Scoreboard bench for dot_tracker: a driver feeds directed and random pixels
// into a set-based game model; a monitor compares every cycle's outputs.
module tb_dot_tracker;

    localparam int          PERIOD = 10;
    localparam int          N      = 16;
    localparam int          PF     = 300;
    localparam logic [15:0] PMASK  = 16'h0011;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       restart = 1'b0;
    logic       pix_valid = 1'b0;
    logic       is_pac = 1'b0;
    logic       dot_hit = 1'b0;
    logic [5:0] dot_idx = '0;

    logic [15:0] a_alive, b_alive;
    logic        a_draw, b_draw, a_pulse, b_pulse, a_pwr, b_pwr, a_lvl, b_lvl;
    logic [9:0]  a_score;
    logic [3:0]  b_score;

    dot_tracker dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .restart(restart),
        .pix_valid(pix_valid), .is_pac(is_pac), .dot_hit(dot_hit), .dot_idx(dot_idx),
        .alive(a_alive), .dot_draw(a_draw), .eat_pulse(a_pulse), .score(a_score),
        .power_active(a_pwr), .level_clear(a_lvl)
    );

    dot_tracker #(.SCORE_W(4)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .restart(restart),
        .pix_valid(pix_valid), .is_pac(is_pac), .dot_hit(dot_hit), .dot_idx(dot_idx),
        .alive(b_alive), .dot_draw(b_draw), .eat_pulse(b_pulse), .score(b_score),
        .power_active(b_pwr), .level_clear(b_lvl)
    );

    always #(PERIOD/2) Clk = ~Clk;

    typedef struct {
        longint      t;
        logic [15:0] alive;
        logic        draw;
        logic        pulse;
        int          score10;
        int          score4;
        logic        pwr;
        logic        lvl;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Game model: a set of eaten dots, plain integer score and frame timer.
    bit eaten[N];
    int m_score10 = 0;
    int m_score4  = 0;
    int m_power   = 0;
    bit m_lvl     = 0;
    bit m_draw    = 0;
    bit m_pulse   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] m_alive();
        logic [15:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = !eaten[i];
        return v;
    endfunction

    function automatic bit all_eaten();
        for (int i = 0; i < N; i++) if (!eaten[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) eaten[i] = 1'b0;
        m_score10 = 0; m_score4 = 0; m_power = 0;
        m_lvl = 0; m_draw = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit pv, input bit pac, input bit hit, input int idx,
                              input bit fs, input bit rs);
        bit vis;
        bit eat;
        bit cleared;
        int pts;
        vis     = (idx < N) ? !eaten[idx] : 1'b0;
        cleared = all_eaten();
        m_draw  = pv && hit && vis;
        eat     = pv && pac && hit && vis && !rs;
        m_pulse = eat;
        m_lvl   = rs ? 1'b0 : (m_lvl || cleared);
        if (rs) begin
            for (int i = 0; i < N; i++) eaten[i] = 1'b0;
            m_power = 0;
        end else begin
            if (eat) begin
                eaten[idx] = 1'b1;
                pts = PMASK[idx] ? 5 : 1;
                m_score10 = (m_score10 + pts > 1023) ? 1023 : m_score10 + pts;
                m_score4  = (m_score4 + pts > 15) ? 15 : m_score4 + pts;
            end
            if (eat && PMASK[idx]) m_power = PF;
            else if (fs && m_power > 0) m_power = m_power - 1;
        end
    endtask

    task automatic push(input longint t);
        sb_q.push_back('{t + PERIOD, m_alive(), m_draw, m_pulse, m_score10, m_score4,
                         m_power > 0, m_lvl});
    endtask

    task automatic step(input bit pv, input bit pac, input bit hit, input int idx,
                        input bit fs, input bit rs);
        longint t;
        @(negedge Clk);
        t = $time;
        #1;
        pix_valid = pv; is_pac = pac; dot_hit = hit; dot_idx = 6'(idx);
        frame_start = fs; restart = rs;
        model_step(pv, pac, hit, idx, fs, rs);
        push(t);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic eat_dot(input int idx);
        step(1, 1, 1, idx, 0, 0);
    endtask

    // Asserts reset between edges and checks that outputs drop with no clock.
    task automatic do_reset();
        longint t;
        @(negedge Clk);
        t = $time;
        #1;
        pix_valid = 0; is_pac = 0; dot_hit = 0; dot_idx = '0;
        frame_start = 0; restart = 0;
        Reset_n = 1'b0;
        #1;
        check("rst_alive", a_alive, 16'hFFFF);
        check("rst_score", a_score, 0);
        check("rst_score4", b_score, 0);
        check("rst_power", a_pwr, 0);
        check("rst_draw", a_draw, 0);
        check("rst_pulse", a_pulse, 0);
        check("rst_lvl", a_lvl, 0);
        model_reset();
        push(t);
        @(negedge Clk);
        t = $time;
        #1;
        push(t);
        @(negedge Clk);
        t = $time;
        #1;
        Reset_n = 1'b1;
        model_step(0, 0, 0, 0, 0, 0);
        push(t);
    endtask

    // Monitor: the DUT presents a result every cycle; compare the tagged one.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (sb_q.size() > 0 && sb_q[0].t < $time) begin
                e = sb_q.pop_front();
                check("sb_stale", e.t, $time);
            end
            if (sb_q.size() > 0 && sb_q[0].t == $time) begin
                e = sb_q.pop_front();
                check("alive", a_alive, e.alive);
                check("alive_b", b_alive, e.alive);
                check("dot_draw", a_draw, e.draw);
                check("eat_pulse", a_pulse, e.pulse);
                check("score", a_score, e.score10);
                check("score_sat4", b_score, e.score4);
                check("power_active", a_pwr, e.pwr);
                check("level_clear", a_lvl, e.lvl);
                check("level_clear_b", b_lvl, e.lvl);
            end
        end
    end

    initial begin
        int wait_cycles;
        do_reset();
        idle(2);

        // Five consecutive player pixels on dot 3 score it once.
        repeat (5) step(1, 1, 1, 3, 0, 0);
        idle(2);

        // Full power window: active through frame 299, gone after frame 300.
        eat_dot(0);
        for (int f = 1; f <= PF; f++) step(0, 0, 0, 0, 1, 0);
        idle(2);

        // Reload mid-window; the 4-bit score climbs 11 -> 13 -> saturates at 15.
        step(0, 0, 0, 0, 0, 1);
        eat_dot(0);
        eat_dot(1);
        eat_dot(2);
        for (int f = 1; f < 150; f++) step(0, 0, 0, 0, 1, 0);
        eat_dot(4);
        for (int f = 0; f <= PF; f++) step(0, 0, 0, 0, 1, 0);
        idle(2);

        // Pellet eaten on a frame_start cycle reloads without the decrement.
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Out-of-range index: no draw, no eat.
        step(1, 1, 1, 20, 0, 0);
        step(1, 0, 1, 20, 0, 0);
        step(1, 0, 1, 9, 0, 0);

        // Restart wins over a simultaneous eat of dot 7.
        step(1, 1, 1, 7, 0, 1);
        idle(2);

        // Clear the whole board, hold, then restart.
        for (int i = 0; i < N; i++) eat_dot(i);
        idle(4);
        step(0, 0, 0, 0, 0, 1);
        idle(2);

        // Random play.
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 23)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end

        // Reset in the middle of power mode.
        step(0, 0, 0, 0, 0, 1);
        eat_dot(0);
        step(0, 0, 0, 0, 1, 0);
        eat_dot(5);
        do_reset();
        idle(3);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(negedge Clk);
            wait_cycles++;
        end
        check("sb_drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
